// File: rtl/pulse_fold_accumulator_if.sv
// ---------------------------------------------------------------------------
// pulse_fold_accumulator_if
// Readout bus of the pulse folding accumulator: one beat per (channel, bin)
// with a valid/ready handshake.
//   out_valid  master -> slave  beat present
//   out_ready  slave  -> master beat accepted when both high
//   out_ch     master -> slave  channel of the current beat
//   out_bin    master -> slave  bin of the current beat
//   out_count  master -> slave  accumulated count of the current beat
//   out_last   master -> slave  final beat of the dump
// ---------------------------------------------------------------------------
interface pulse_fold_accumulator_if #(
   parameter int N_CH     = 4,
   parameter int BIN_BITS = 6,
   parameter int CNT_W    = 16
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                out_valid;
   logic                out_ready;
   logic [CH_W-1:0]     out_ch;
   logic [BIN_BITS-1:0] out_bin;
   logic [CNT_W-1:0]    out_count;
   logic                out_last;

   modport master (
      output out_valid, out_ch, out_bin, out_count, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_ch, out_bin, out_count, out_last,
      output out_ready
   );
endinterface

// File: rtl/pulse_fold_accumulator.sv
// ---------------------------------------------------------------------------
// pulse_fold_accumulator
// Folds rising edges of N_CH pulse channels into a phase-binned profile.
// A 32-bit phase accumulator advances by a fixed step every cycle; its top
// BIN_BITS select the bin that an edge is counted into. After n_periods
// phase wraps the profile is streamed out channel-major, bin-minor.
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   i_start       begin a run (honoured in IDLE only)
//   i_phase_step  phase increment per cycle (2^32 = one period)
//   i_phase_init  phase loaded at start
//   i_n_periods   number of wraps to fold (0 = dump straight away)
//   i_pulse_in    raw pulse levels, one bit per channel
//   o_busy        high whenever not IDLE
//   o_done        one-cycle pulse after the last beat is accepted
//   o_rd          readout bus (master side)
// ---------------------------------------------------------------------------
module pulse_fold_accumulator #(
   parameter int N_CH     = 4,
   parameter int BIN_BITS = 6,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic [31:0]              i_phase_step,
   input  logic [31:0]              i_phase_init,
   input  logic [15:0]              i_n_periods,
   input  logic [N_CH-1:0]          i_pulse_in,
   output logic                     o_busy,
   output logic                     o_done,
   pulse_fold_accumulator_if.master o_rd
);
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int N_BINS = 2 ** BIN_BITS;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FOLD = 2'd1;
   localparam logic [1:0] ST_DUMP = 2'd2;

   localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(N_CH - 1);
   localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

   logic [1:0]          r_state;
   logic [31:0]         r_phase_acc;
   logic [31:0]         r_phase_step;
   logic [15:0]         r_n_periods;
   logic [15:0]         r_wrap_cnt;
   logic [N_CH-1:0]     r_prev;
   logic [CH_W-1:0]     r_ch;
   logic [BIN_BITS-1:0] r_bin;
   logic                r_done;

   logic [N_CH-1:0]     w_edge;
   logic [BIN_BITS-1:0] w_bin;
   logic [31:0]         w_phase_sum;
   logic                w_carry;
   logic [15:0]         w_wrap_next;
   logic                w_fold_end;
   logic                w_in_fold;
   logic                w_start_acc;
   logic                w_beat_acc;
   logic                w_last;
   logic [CNT_W-1:0]    w_rd_count [N_CH];

   assign w_edge      = i_pulse_in & ~r_prev;
   // Bin comes from the phase before this cycle's increment.
   assign w_bin       = r_phase_acc[31 -: BIN_BITS];
   assign {w_carry, w_phase_sum} = {1'b0, r_phase_acc} + {1'b0, r_phase_step};
   assign w_wrap_next = r_wrap_cnt + 16'd1;
   assign w_fold_end  = w_carry && (w_wrap_next == r_n_periods);
   assign w_in_fold   = (r_state == ST_FOLD);
   assign w_start_acc = (r_state == ST_IDLE) && i_start;
   assign w_beat_acc  = (r_state == ST_DUMP) && o_rd.out_ready;
   assign w_last      = (r_ch == LAST_CH) && (r_bin == LAST_BIN);

   // One independent counter bank per channel so simultaneous edges on
   // different channels never contend for a write port.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_count [N_BINS];

      always_ff @(posedge clk) begin
         if (rst || w_start_acc) begin
            for (int b = 0; b < N_BINS; b++) begin
               r_count[b] <= '0;
            end
         end else if (w_in_fold && w_edge[gi] && (r_count[w_bin] != '1)) begin
            r_count[w_bin] <= r_count[w_bin] + CNT_W'(1);
         end
      end

      assign w_rd_count[gi] = r_count[r_bin];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_phase_acc  <= '0;
         r_phase_step <= '0;
         r_n_periods  <= '0;
         r_wrap_cnt   <= '0;
         r_prev       <= '0;
         r_ch         <= '0;
         r_bin        <= '0;
         r_done       <= 1'b0;
      end else begin
         r_prev <= i_pulse_in;
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_phase_step <= i_phase_step;
                  r_n_periods  <= i_n_periods;
                  r_phase_acc  <= i_phase_init;
                  r_wrap_cnt   <= '0;
                  r_ch         <= '0;
                  r_bin        <= '0;
                  r_state      <= (i_n_periods == 16'd0) ? ST_DUMP : ST_FOLD;
               end
            end
            ST_FOLD: begin
               r_phase_acc <= w_phase_sum;
               if (w_carry) begin
                  r_wrap_cnt <= w_wrap_next;
               end
               if (w_fold_end) begin
                  r_state <= ST_DUMP;
               end
            end
            ST_DUMP: begin
               if (w_beat_acc) begin
                  r_bin <= r_bin + BIN_BITS'(1);
                  if (w_last) begin
                     r_ch    <= '0;
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end else if (r_bin == LAST_BIN) begin
                     r_ch <= r_ch + CH_W'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy         = (r_state != ST_IDLE);
   assign o_done         = r_done;
   assign o_rd.out_valid = (r_state == ST_DUMP);
   assign o_rd.out_ch    = r_ch;
   assign o_rd.out_bin   = r_bin;
   assign o_rd.out_count = w_rd_count[r_ch];
   assign o_rd.out_last  = (r_state == ST_DUMP) && w_last;
endmodule
